// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, LSB first, with a registered serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tx_start,
   input  logic            s_tick,
   input  logic [DBIT-1:0] din,
   output logic            tx_done_tick,
   output logic            tx,
   output logic            tx_busy
);

   localparam int unsigned TMAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int unsigned TW   = $clog2(TMAX);
   localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TW-1:0] BIT_LAST  = TW'(15);
   localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
   localparam logic [NW-1:0] DATA_LAST = NW'(DBIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state_reg, state_next;
   logic [TW-1:0]   s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
   logic            par_reg, par_next;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
         par_reg   <= par_next;
`endif
      end
   end

   // tx_next carries the level of the state being entered, so tx stays registered
   always_comb begin
      state_next   = state_reg;
      s_next       = s_reg;
      n_next       = n_reg;
      b_next       = b_reg;
      tx_next      = tx_reg;
      tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_next     = par_reg;
`endif
      unique case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (tx_start) begin
               state_next = START;
               s_next     = '0;
               b_next     = din;
               tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_next   = ^din;
`endif
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == BIT_LAST) begin
                  state_next = DATA;
                  s_next     = '0;
                  n_next     = '0;
                  tx_next    = b_reg[0];
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == BIT_LAST) begin
                  s_next = '0;
                  b_next = b_reg >> 1;
                  if (n_reg == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_next = PARITY;
                     tx_next    = par_reg;
`else
                     state_next = STOP;
                     tx_next    = 1'b1;
`endif
                  end else begin
                     n_next  = n_reg + 1'b1;
                     tx_next = b_next[0];
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_reg == BIT_LAST) begin
                  state_next = STOP;
                  s_next     = '0;
                  tx_next    = 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
`endif
         STOP: begin
            tx_next = 1'b1;
            if (s_tick) begin
               if (s_reg == STOP_LAST) begin
                  state_next   = IDLE;
                  tx_done_tick = 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign tx      = tx_reg;
   assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, corner sequences and random traffic
// compared every clk against a tick-counting frame model.
module tb_uart_tx;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME_TICKS = 16 * (1 + DBIT + PAR) + SB_TICK;
   localparam int SLOTS       = 2 + DBIT + PAR;
   localparam int BOUND       = 8 * FRAME_TICKS;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       tx_start = 1'b0;
   logic       s_tick   = 1'b0;
   logic [7:0] din      = '0;
   logic       tx_done_tick, tx, tx_busy;

   uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_start     (tx_start),
      .s_tick       (s_tick),
      .din          (din),
      .tx_done_tick (tx_done_tick),
      .tx           (tx),
      .tx_busy      (tx_busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // model: a frame is a list of 16-tick slots; position is strobes seen since acceptance
   bit         m_busy  = 1'b0;
   int         m_ticks = 0;
   logic [7:0] m_data  = '0;
   int         phase   = 0;
   int         done_seen  = 0;
   int         done_ticks = 0;
   logic       cap [SLOTS];

   typedef struct {
      logic [7:0] din;
      logic [9:0] frame;
      logic       par;
      bit         disturb;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_level(input int slot, input logic [7:0] d);
      if (slot == 0) return 1'b0;
      if (slot <= DBIT) return d[slot-1];
      if (PAR == 1 && slot == DBIT + 1) return ^d;
      return 1'b1;
   endfunction

   task automatic step(input logic start, input logic [7:0] d);
      bit ticked;
      bit exp_done;
      tx_start = start;
      din      = d;
      s_tick   = (phase == 0);
      phase    = (phase + 1) % 4;
      #2;
      exp_done = reset && m_busy && s_tick && (m_ticks == FRAME_TICKS - 1);
      check("done", tx_done_tick, exp_done);
      if (tx_done_tick === 1'b1) begin
         done_seen++;
         done_ticks = m_ticks + 1;
      end
      ticked = 1'b0;
      if (!reset) begin
         m_busy  = 1'b0;
         m_ticks = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy  = 1'b1;
            m_ticks = 0;
            m_data  = d;
         end
      end else if (s_tick) begin
         m_ticks++;
         ticked = 1'b1;
         if (m_ticks == FRAME_TICKS) m_busy = 1'b0;
      end
      @(posedge clk);
      #1;
      if (ticked && m_busy && (m_ticks % 16) == 8) cap[m_ticks / 16] = tx;
      check("tx", tx, m_busy ? exp_level(m_ticks / 16, m_data) : 1'b1);
      check("busy", tx_busy, m_busy);
   endtask

   task automatic clear_capture();
      foreach (cap[i]) cap[i] = 1'bx;
      done_seen  = 0;
      done_ticks = 0;
   endtask

   task automatic check_capture(input string tag, input logic [9:0] frame, input logic par);
      for (int i = 0; i <= DBIT; i++)
         check($sformatf("%s_slot%0d", tag, i), cap[i], frame[i]);
      if (PAR == 1) check($sformatf("%s_parity", tag), cap[DBIT+1], par);
      check($sformatf("%s_stop", tag), cap[SLOTS-1], frame[9]);
   endtask

   task automatic run_frame(input vec_t v);
      int n;
      clear_capture();
      step(1'b1, v.din);
      n = 0;
      while (m_busy && n < BOUND) begin
         if (v.disturb && m_ticks >= 40) step(m_ticks == 40, 8'hFF);
         else                            step(1'b0, v.din);
         n++;
      end
      repeat (6) step(1'b0, v.din);
      check_capture($sformatf("frame_%02h", v.din), v.frame, v.par);
      check("done_count", done_seen, 1);
      check("done_ticks", done_ticks, FRAME_TICKS);
   endtask

   initial begin
      int   n, gap;
      logic cap_a [SLOTS];
      logic [7:0] d;

      vecs[0] = '{8'h41, 10'h282, 1'b0, 1'b0};
      vecs[1] = '{8'h2D, 10'h25A, 1'b0, 1'b1};
      vecs[2] = '{8'h0D, 10'h21A, 1'b1, 1'b0};
      vecs[3] = '{8'h0A, 10'h214, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 10'h200, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 10'h3FE, 1'b0, 1'b0};
      vecs[6] = '{8'h55, 10'h2AA, 1'b0, 1'b0};
      vecs[7] = '{8'h37, 10'h26E, 1'b1, 1'b0};

      // reset held, released, then a long quiet idle
      @(posedge clk);
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      repeat (5) step(1'b0, 8'hA5);
      reset = 1'b1;
      clear_capture();
      repeat (1000) step(1'b0, 8'($urandom));
      check("idle_no_done", done_seen, 0);

      foreach (vecs[i]) run_frame(vecs[i]);

      // CR then LF with tx_start held high throughout
      clear_capture();
      gap = 0;
      n   = 0;
      while (done_seen < 2 && n < BOUND) begin
         step(1'b1, (done_seen == 0) ? 8'h0D : 8'h0A);
         if (done_seen == 1 && gap == 0 && tx_busy === 1'b0) begin
            foreach (cap[i]) cap_a[i] = cap[i];
         end
         if (done_seen == 1 && tx_busy === 1'b0) gap++;
         n++;
      end
      check("b2b_timeout", n < BOUND, 1'b1);
      repeat (10) step(1'b0, 8'h0A);
      check("b2b_done_count", done_seen, 2);
      check("b2b_idle_gap", gap, 1);
      check_capture("lf", 10'h214, 1'b0);
      foreach (cap[i]) cap[i] = cap_a[i];
      check_capture("cr", 10'h21A, 1'b1);

      // asynchronous reset in the middle of a frame
      clear_capture();
      step(1'b1, 8'h41);
      n = 0;
      while (m_ticks != 70 && n < BOUND) begin
         step(1'b0, 8'h41);
         n++;
      end
      check("tick70_reached", m_ticks, 70);
      #1 reset = 1'b0;
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_busy", tx_busy, 1'b0);
      check("async_rst_done", tx_done_tick, 1'b0);
      m_busy = 1'b0;
      repeat (3) step(1'b0, 8'h41);
      reset = 1'b1;
      repeat (20) step(1'b0, 8'h41);
      check("abort_no_done", done_seen, 0);
      run_frame(vecs[0]);

      // random traffic with stray requests and din noise during frames
      for (int r = 0; r < 30; r++) begin
         d = 8'($urandom);
         repeat ($urandom_range(0, 3)) step(1'b0, 8'($urandom));
         clear_capture();
         step(1'b1, d);
         n = 0;
         while (m_busy && n < BOUND) begin
            step($urandom_range(0, 7) == 0, 8'($urandom));
            n++;
         end
         check("rand_done_count", done_seen, 1);
         check("rand_done_ticks", done_ticks, FRAME_TICKS);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DBIT, default 8, number of data bits per frame.
REQ-002 Parameter: SB_TICK, default 16, number of s_tick periods in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (low) resets the block immediately, independent of clk.
REQ-005 tx_start  input  1  level request to send din; sampled only in idle.
REQ-006 s_tick  input  1  one-clk-wide oversampling strobe at 16x the baud rate.
REQ-007 din  input  DBIT  byte to transmit (ASCII from the upstream formatter).
REQ-008 tx_done_tick  output  1  one-clk pulse marking frame completion.
REQ-009 tx  output  1  serial line; idles high.
REQ-010 tx_busy  output  1  high whenever the state is not idle.

Function
REQ-011 FSM states: idle, start, data, parity (Configuration only), stop.
REQ-012 idle: tx=1, counters held. On an edge with tx_start=1: latch din into the shift register, clear the tick counter, and go to start. tx_start=0 stays in idle.
REQ-013 start: tx=0 for exactly 16 s_tick strobes. On the 16th strobe, clear the tick counter and bit counter, and go to data.
REQ-014 data: tx = shift register bit 0, sent LSB first. Each bit lasts 16 s_tick strobes; on the 16th, shift right by one and increment the bit counter. After bit DBIT-1, go to parity (if compiled in) or stop.
REQ-015 stop: tx=1 for SB_TICK strobes. On the final strobe, assert tx_done_tick combinationally for that single clk cycle and return to idle on the same edge.
REQ-016 Frame length in s_tick strobes: 16*(1+DBIT) + SB_TICK, plus 16 if parity is enabled.
REQ-017 Counters advance only on clk edges where s_tick=1. Clk cycles without s_tick change no state.
REQ-018 tx is driven from a register (no combinational glitches). It changes only on state or bit boundaries.
REQ-019 din is sampled only at the idle->start transition. Changes to din during a frame do not affect that frame.
REQ-020 tx_start asserted while busy is ignored. No request is queued.
REQ-021 Back-to-back frames: if tx_start is still high on the first edge after the tx_done_tick edge, the next frame starts from idle with no extra idle tick. The upstream holds tx_start high across consecutive characters (e.g. CR then LF).
REQ-022 tx_done_tick never fires outside stop, and fires exactly once per frame.
REQ-023 tx_busy = 0 in idle only. It rises on the edge after tx_start is accepted and falls on the tx_done_tick edge.

Reset
REQ-024 While reset=0, and on its deassertion: state=idle, tx=1, tx_busy=0, tx_done_tick=0, tick counter=0, bit counter=0, shift register=0.
REQ-025 Reset mid-frame aborts the frame immediately. tx returns high without waiting for clk, and no tx_done_tick is issued.

Configuration
REQ-026 Macro UART_TX_PARITY_EN.
- Defined: insert the parity state after data. tx = even parity (XOR of the latched DBIT bits) for 16 strobes, then go to stop.
- Undefined: no parity state, no parity logic; data goes directly to stop.

Verification
REQ-027 Setup for all scenarios: s_tick every 4 clk, DBIT=8, SB_TICK=16, parity undefined unless stated.
- Reset held low, then released -> tx=1, tx_busy=0, no tx_done_tick for 1000 clk.
REQ-028 din=8'h41 ('A'), tx_start pulse -> tx bits 0,1,0,0,0,0,0,1,0,1, each 16 ticks (64 clk). One tx_done_tick after 160 ticks.
REQ-029 tx_start held high; din=8'h0D, switched to 8'h0A after the first tx_done_tick -> two contiguous frames: stop bit of CR followed directly by start bit of LF. Exactly two tx_done_tick pulses.
REQ-030 During a frame of 8'h2D ('-'): toggle din to 8'hFF and pulse tx_start -> transmitted bits still 0,1,0,1,1,0,1,0,0,1. Only one tx_done_tick.
REQ-031 reset driven low at tick 70 of a frame -> tx=1 in the same cycle, state idle, no tx_done_tick. A new tx_start then sends a complete frame.
REQ-032 UART_TX_PARITY_EN defined, din=8'h37 -> parity bit 1 sent after the data bits, stop bit follows. tx_done_tick after 176 ticks.
